mem_arbiter: RTL and testbench

//  Parametrised byte-serial arbiter between the core and the 8-bit unified RAM/IO port.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Core request/response signals and the 8-bit RAM/IO byte port seen by mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 4
);
  logic                    rdy;
  logic                    clear;
  logic                    uart_full;

  logic                    fetch_req;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    fetch_done;
  logic [LINE_BYTES*8-1:0] fetch_line;

  logic                    load_req;
  logic [ADDR_W-1:0]       load_addr;
  logic [2:0]              load_size;
  logic                    load_signed;
  logic                    load_done;
  logic [31:0]             load_data;

  logic                    store_req;
  logic [ADDR_W-1:0]       store_addr;
  logic [2:0]              store_size;
  logic [31:0]             store_data;
  logic                    store_done;

  logic                    ram_wr;
  logic [ADDR_W-1:0]       ram_addr;
  logic [7:0]              ram_dout;
  logic [7:0]              ram_din;
  logic                    busy;

  modport slave (
    input  rdy, clear, uart_full,
    input  fetch_req, fetch_addr,
    input  load_req, load_addr, load_size, load_signed,
    input  store_req, store_addr, store_size, store_data,
    input  ram_din,
    output fetch_done, fetch_line, load_done, load_data, store_done,
    output ram_wr, ram_addr, ram_dout, busy
  );

  modport master (
    output rdy, clear, uart_full,
    output fetch_req, fetch_addr,
    output load_req, load_addr, load_size, load_signed,
    output store_req, store_addr, store_size, store_data,
    output ram_din,
    input  fetch_done, fetch_line, load_done, load_data, store_done,
    input  ram_wr, ram_addr, ram_dout, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter of instruction fetch, loads and stores onto the shared 8-bit RAM/IO port.
module mem_arbiter #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       LINE_BYTES = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = 'h30000,
  parameter int unsigned       STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned CNT_W  = $clog2(LINE_BYTES + 2);
  localparam int unsigned STV_W  = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, LOAD = 2'd2, STORE = 2'd3} state_t;

  state_t            state_q, state_d, gnt;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, nxt;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       sdata_q, sdata_d, load_data_q, load_data_d;
  logic [LINE_W-1:0] buf_q, buf_d, fetch_line_q, fetch_line_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              fetch_done_q, fetch_done_d, load_done_q, load_done_d;
  logic              store_done_q, store_done_d, ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              any_done, io_block;

  function automatic logic [CNT_W-1:0] size_len(input logic [2:0] s);
    case (s)
      3'd1:    return CNT_W'(1);
      3'd2:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [CNT_W-1:0] len,
                                         input logic sg);
    if (len == CNT_W'(1)) return {{24{sg & w[7]}}, w[7:0]};
    if (len == CNT_W'(2)) return {{16{sg & w[15]}}, w[15:0]};
    return w;
  endfunction

  function automatic logic [7:0] st_byte(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  // A pending done pulse or a stalled IO store blocks every grant, keeping program order.
  assign any_done = fetch_done_q | load_done_q | store_done_q;
  assign io_block = bus.store_req && (bus.store_addr >= IO_BASE) && bus.uart_full;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    sgn_d        = sgn_q;
    sdata_d      = sdata_q;
    buf_d        = buf_q;
    fetch_line_d = fetch_line_q;
    load_data_d  = load_data_q;
    ram_addr_d   = ram_addr_q;
    ram_wr_d     = ram_wr_q;
    ram_dout_d   = ram_dout_q;
    starve_d     = starve_q;
    fetch_done_d = 1'b0;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    gnt          = IDLE;
    nxt          = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (!any_done && !bus.clear && !io_block) begin
          if (bus.fetch_req && starve_q == STV_W'(STARVE_MAX)) gnt = FETCH;
          else if (bus.store_req)                                gnt = STORE;
          else if (bus.load_req)                                 gnt = LOAD;
          else if (bus.fetch_req)                                gnt = FETCH;
        end
      end
      FETCH, LOAD: begin
        if (bus.clear) begin
          state_d    = IDLE;
          cnt_d      = '0;
          ram_addr_d = '0;
        end else begin
          cnt_d = nxt;
          // Byte c was addressed during the cycle just ending; capture it now.
          for (int k = 0; k < LINE_BYTES; k++) begin
            if (cnt_q == CNT_W'(k) && cnt_q < len_q) buf_d[8*k +: 8] = bus.ram_din;
          end
          ram_addr_d = (nxt < len_q) ? base_q + ADDR_W'(nxt) : '0;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == FETCH) begin
              fetch_done_d = 1'b1;
              fetch_line_d = buf_q;
            end else begin
              load_done_d = 1'b1;
              load_data_d = extend(buf_q[31:0], len_q, sgn_q);
            end
          end
        end
      end
      STORE: begin
        // Stores ignore clear: a committed store always completes.
        if (nxt < len_q) begin
          cnt_d      = nxt;
          ram_addr_d = base_q + ADDR_W'(nxt);
          ram_dout_d = st_byte(sdata_q, nxt[1:0]);
        end else begin
          state_d      = IDLE;
          cnt_d        = '0;
          ram_wr_d     = 1'b0;
          ram_addr_d   = '0;
          ram_dout_d   = '0;
          store_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (gnt)
      FETCH: begin
        base_d     = bus.fetch_addr;
        len_d      = CNT_W'(LINE_BYTES);
        ram_addr_d = bus.fetch_addr;
      end
      LOAD: begin
        base_d     = bus.load_addr;
        len_d      = size_len(bus.load_size);
        sgn_d      = bus.load_signed;
        ram_addr_d = bus.load_addr;
      end
      STORE: begin
        base_d     = bus.store_addr;
        len_d      = size_len(bus.store_size);
        sdata_d    = bus.store_data;
        ram_addr_d = bus.store_addr;
        ram_wr_d   = 1'b1;
        ram_dout_d = bus.store_data[7:0];
      end
      default: ;
    endcase
    if (gnt != IDLE) begin
      state_d = gnt;
      cnt_d   = '0;
    end

    if (!bus.fetch_req || bus.clear || gnt == FETCH) starve_d = '0;
    else if ((gnt == LOAD || gnt == STORE) && starve_q != STV_W'(STARVE_MAX))
      starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      sgn_q        <= 1'b0;
      sdata_q      <= '0;
      buf_q        <= '0;
      fetch_line_q <= '0;
      load_data_q  <= '0;
      ram_addr_q   <= '0;
      ram_wr_q     <= 1'b0;
      ram_dout_q   <= '0;
      starve_q     <= '0;
      fetch_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else if (bus.rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      sgn_q        <= sgn_d;
      sdata_q      <= sdata_d;
      buf_q        <= buf_d;
      fetch_line_q <= fetch_line_d;
      load_data_q  <= load_data_d;
      ram_addr_q   <= ram_addr_d;
      ram_wr_q     <= ram_wr_d;
      ram_dout_q   <= ram_dout_d;
      starve_q     <= starve_d;
      fetch_done_q <= fetch_done_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
    end
  end

  assign bus.fetch_done = fetch_done_q;
  assign bus.fetch_line = fetch_line_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_data  = load_data_q;
  assign bus.store_done = store_done_q;
  assign bus.ram_wr     = ram_wr_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_dout   = ram_dout_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, monitor checks writes, done data and latency.
module tb_mem_arbiter;
  localparam int unsigned LB = 16;
  localparam int unsigned LW = LB * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .LINE_BYTES(LB)) bus ();

  mem_arbiter #(.ADDR_W(32), .LINE_BYTES(LB), .IO_BASE(32'h30000), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Byte memory: combinational read of the presented address, write on rdy edges.
  logic [7:0] mem [0:4095];
  assign bus.ram_din = mem[bus.ram_addr[11:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[12'h100] <= 8'h80;
      mem[12'h110] <= 8'h34;
      mem[12'h111] <= 8'hF2;
    end else if (bus.rdy && bus.ram_wr) begin
      mem[bus.ram_addr[11:0]] <= bus.ram_dout;
    end
  end

  typedef struct { int kind; logic [LW-1:0] data; int lat; } resp_t;
  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_at(input logic [31:0] base);
    logic [LW-1:0] r;
    for (int k = 0; k < LB; k++) r[8*k +: 8] = 8'(base + 32'(k)) ^ 8'h5A;
    return r;
  endfunction

  task automatic push_resp(input int kind, input logic [LW-1:0] d, input int lat);
    resp_t r;
    r.kind = kind; r.data = d; r.lat = lat;
    exp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // Monitor: latency counted from the first cycle busy is seen.
  int   cyc = 0;
  int   g_cyc = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    resp_t r;
    wr_t w;
    int kind;
    logic [LW-1:0] act;
    cyc++;
    if (bus.busy === 1'b1 && !busy_prev) g_cyc = cyc;
    busy_prev = (bus.busy === 1'b1);
    if (bus.rdy === 1'b1 && bus.ram_wr === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected write: got addr %0h data %0h, want no write", bus.ram_addr, bus.ram_dout);
      end else begin
        w = wr_q.pop_front();
        check("write addr", LW'(bus.ram_addr), LW'(w.addr));
        check("write data", LW'(bus.ram_dout), LW'(w.data));
      end
    end
    if (bus.rdy === 1'b1 && (bus.fetch_done | bus.load_done | bus.store_done) === 1'b1) begin
      kind = bus.fetch_done ? 0 : (bus.load_done ? 1 : 2);
      act  = (kind == 0) ? bus.fetch_line : ((kind == 1) ? LW'(bus.load_data) : '0);
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected done: got kind %0d, want none", kind);
      end else begin
        r = exp_q.pop_front();
        check("done kind", LW'(kind), LW'(r.kind));
        check("done data", act, r.data);
        check("done latency", LW'(cyc - g_cyc), LW'(r.lat));
        check("done ram_addr", LW'(bus.ram_addr), '0);
        check("done ram_wr", LW'(bus.ram_wr), '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int kind, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (kind == 0)      seen = bus.rdy && bus.fetch_done;
      else if (kind == 1) seen = bus.rdy && bus.load_done;
      else                seen = bus.rdy && bus.store_done;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: got no done in 400 cycles, want done", nm);
    end
  endtask

  task automatic wait_busy(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = bus.busy;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s grant timeout: got busy 0, want 1", nm);
    end
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] sz, input logic sg,
                          input logic [31:0] exp, input int lat);
    push_resp(1, LW'(exp), lat);
    bus.load_addr = a; bus.load_size = sz; bus.load_signed = sg;
    bus.load_req = 1'b1;
    wait_done(1, "load");
    bus.load_req = 1'b0;
    tick(); tick();
  endtask

  task automatic run_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                           input int lat);
    push_resp(2, '0, lat);
    bus.store_addr = a; bus.store_size = sz; bus.store_data = d;
    bus.store_req = 1'b1;
    wait_done(2, "store");
    bus.store_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    rst = 1'b1;
    bus.rdy = 1'b1; bus.clear = 1'b0; bus.uart_full = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.load_req = 1'b0; bus.load_addr = '0; bus.load_size = 3'd1; bus.load_signed = 1'b0;
    bus.store_req = 1'b0; bus.store_addr = '0; bus.store_size = 3'd1; bus.store_data = '0;
    repeat (3) tick();
    check("reset fetch_done", LW'(bus.fetch_done), '0);
    check("reset fetch_line", bus.fetch_line, '0);
    check("reset load_done", LW'(bus.load_done), '0);
    check("reset load_data", LW'(bus.load_data), '0);
    check("reset store_done", LW'(bus.store_done), '0);
    check("reset ram_wr", LW'(bus.ram_wr), '0);
    check("reset ram_addr", LW'(bus.ram_addr), '0);
    check("reset ram_dout", LW'(bus.ram_dout), '0);
    check("reset busy", LW'(bus.busy), '0);
    rst = 1'b0;
    tick();

    // Single loads: sign/zero extension and latency N+1.
    run_load(32'h100, 3'd1, 1'b1, 32'hFFFF_FF80, 2);
    run_load(32'h100, 3'd1, 1'b0, 32'h0000_0080, 2);
    run_load(32'h110, 3'd2, 1'b1, 32'hFFFF_F234, 3);
    run_load(32'h110, 3'd2, 1'b0, 32'h0000_F234, 3);

    // Stores of each size, then read back; size 7 behaves as 4.
    push_wr(32'h200, 8'hEF); push_wr(32'h201, 8'hBE); push_wr(32'h202, 8'hAD); push_wr(32'h203, 8'hDE);
    run_store(32'h200, 3'd4, 32'hDEAD_BEEF, 4);
    push_wr(32'h210, 8'h77);
    run_store(32'h210, 3'd1, 32'h1234_5677, 1);
    push_wr(32'h220, 8'h34); push_wr(32'h221, 8'h12);
    run_store(32'h220, 3'd2, 32'hAAAA_1234, 2);
    run_load(32'h200, 3'd4, 1'b0, 32'hDEAD_BEEF, 5);
    run_load(32'h220, 3'd7, 1'b1, 32'h7978_1234, 5);

    // Starvation bound: L,L,L,L,F twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push_resp(1, LW'(32'h5D5C_5F5E), 5);
      push_resp(0, line_at(32'h300), 17);
    end
    bus.load_addr = 32'h104; bus.load_size = 3'd4; bus.load_signed = 1'b0;
    bus.fetch_addr = 32'h300;
    fork
      begin
        bus.load_req = 1'b1;
        for (int i = 0; i < 8; i++) wait_done(1, "starve load");
        bus.load_req = 1'b0;
      end
      begin
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 2; i++) wait_done(0, "starve fetch");
        bus.fetch_req = 1'b0;
      end
    join
    tick(); tick();

    // IO store held off by uart_full blocks the pending load too.
    push_resp(2, '0, 1);
    push_wr(32'h30000, 8'h55);
    push_resp(1, LW'(32'h0000_0080), 2);
    bus.uart_full = 1'b1;
    bus.store_addr = 32'h30000; bus.store_size = 3'd1; bus.store_data = 32'h0000_0055;
    bus.load_addr = 32'h100; bus.load_size = 3'd1; bus.load_signed = 1'b0;
    bus.store_req = 1'b1; bus.load_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("io hold busy", LW'(bus.busy), '0);
    end
    bus.uart_full = 1'b0;
    fork
      begin wait_done(2, "io store"); bus.store_req = 1'b0; end
      begin wait_done(1, "io load");  bus.load_req = 1'b0;  end
    join
    tick(); tick();

    // Clear at byte 2 of a 4-byte load aborts it.
    bus.load_addr = 32'h104; bus.load_size = 3'd4; bus.load_signed = 1'b0;
    bus.load_req = 1'b1;
    wait_busy("clear load");
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0; bus.load_req = 1'b0;
    check("clear load busy", LW'(bus.busy), '0);
    check("clear load ram_addr", LW'(bus.ram_addr), '0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.load_done) saw_done = 1'b1;
    end
    check("clear load no done", LW'(saw_done), '0);

    // Clear during a store does not stop it.
    push_wr(32'h230, 8'h04); push_wr(32'h231, 8'h03); push_wr(32'h232, 8'h02); push_wr(32'h233, 8'h01);
    push_resp(2, '0, 4);
    bus.store_addr = 32'h230; bus.store_size = 3'd4; bus.store_data = 32'h0102_0304;
    bus.store_req = 1'b1;
    wait_busy("clear store");
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    wait_done(2, "clear store");
    bus.store_req = 1'b0;
    tick(); tick();

    // rdy low for 3 cycles mid-fetch freezes the port and delays done by 3.
    push_resp(0, line_at(32'h300), 20);
    bus.fetch_addr = 32'h300;
    bus.fetch_req = 1'b1;
    wait_busy("stall fetch");
    tick(); tick(); tick();
    check("stall pre ram_addr", LW'(bus.ram_addr), LW'(32'h303));
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall ram_addr", LW'(bus.ram_addr), LW'(32'h303));
      check("stall ram_wr", LW'(bus.ram_wr), '0);
    end
    bus.rdy = 1'b1;
    wait_done(0, "stall fetch");
    bus.fetch_req = 1'b0;
    repeat (4) tick();

    check("pending responses", LW'(exp_q.size()), '0);
    check("pending writes", LW'(wr_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
